// File: rtl/mux21_pkg.sv
// Shared defaults for the mux21 block family.
package mux21_pkg;

  localparam int unsigned MUX21_WIDTH_DEF = 1;
  localparam int unsigned MUX21_CNT_W_DEF = 16;

endpackage : mux21_pkg

// File: rtl/mux21_core.sv
// Purely combinational 2:1 select: s=0 routes a, s=1 routes b.
module mux21_core
  import mux21_pkg::*;
#(
  parameter int unsigned WIDTH = MUX21_WIDTH_DEF
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    if (s) y = b;
  end

endmodule : mux21_core

// File: rtl/mux21_a.sv
// 2:1 mux with a registered copy of its output and a saturating count of select transitions.
module mux21_a
  import mux21_pkg::*;
#(
  parameter int unsigned WIDTH = MUX21_WIDTH_DEF,
  parameter int unsigned CNT_W = MUX21_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] sw_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s_q;
  logic [CNT_W-1:0] sw_cnt_nxt;

  mux21_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .s (s),
    .a (a),
    .b (b),
    .y (y)
  );

  // Only a difference visible at the edge counts; the counter sticks at all-ones.
  always_comb begin
    sw_cnt_nxt = sw_cnt;
    if ((s != s_q) && (sw_cnt != CNT_MAX)) begin
      sw_cnt_nxt = sw_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      s_q    <= 1'b0;
      sw_cnt <= '0;
    end else begin
      y_q    <= y;
      s_q    <= s;
      sw_cnt <= sw_cnt_nxt;
    end
  end

endmodule : mux21_a

// File: tb/tb_mux21_a.sv
// Directed self-checking bench for mux21_a across three parameterisations.
module tb_mux21_a;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n = 1'b0;

  logic        s1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic        y1, y_q1;
  logic [15:0] sw_cnt1;

  logic        s8 = 1'b0;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00;
  logic [7:0]  y8, y_q8;
  logic [15:0] sw_cnt8;

  logic        s2 = 1'b0, a2 = 1'b0, b2 = 1'b0;
  logic        y2, y_q2;
  logic [1:0]  sw_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 if (clk_run) clk = ~clk;

  mux21_a #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .s(s1), .a(a1), .b(b1),
    .y(y1), .y_q(y_q1), .sw_cnt(sw_cnt1)
  );

  mux21_a #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .s(s8), .a(a8), .b(b8),
    .y(y8), .y_q(y_q8), .sw_cnt(sw_cnt8)
  );

  mux21_a #(.WIDTH(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s(s2), .a(a2), .b(b2),
    .y(y2), .y_q(y_q2), .sw_cnt(sw_cnt2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] vec [8];
    logic       y_exp [8];
    logic [1:0] sat_exp [6];
    logic       s_prev;

    vec   = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    y_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    // Combinational sweep with the clock stopped and reset held.
    #1;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, s1} = vec[i];
      #10;
      check($sformatf("sweep_%0d", i), 16'(y1), 16'(y_exp[i]));
    end

    // Reset held with a running clock: y still muxes, registers stay cleared.
    a1 = 1'b1; b1 = 1'b0; s1 = 1'b0;
    clk_run = 1'b1;
    tick();
    tick();
    check("rst_y", 16'(y1), 16'h1);
    check("rst_y_q", 16'(y_q1), 16'h0);
    check("rst_sw_cnt", sw_cnt1, 16'h0);

    // Release reset; s=1 on the first edge counts because s_q resets to 0.
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b1; s1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_prev = s1;
      tick();
      check($sformatf("toggle_cnt_%0d", i), sw_cnt1, 16'(i + 1));
      check($sformatf("toggle_y_q_%0d", i), 16'(y_q1), 16'(s_prev));
      if (i < 4) s1 = ~s1;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_cnt_%0d", i), sw_cnt1, 16'd5);
    end

    // Glitch s between edges from a settled s=0.
    s1 = 1'b0;
    tick();
    check("pre_glitch_cnt", sw_cnt1, 16'd6);
    s1 = 1'b1;
    #1;
    check("glitch_y_b", 16'(y1), 16'h1);
    s1 = 1'b0;
    #1;
    check("glitch_y_a", 16'(y1), 16'h0);
    tick();
    check("glitch_cnt", sw_cnt1, 16'd6);

    // Wide data path: immediate y, one-cycle y_q.
    a8 = 8'h5A; b8 = 8'hA5; s8 = 1'b0;
    #1;
    check("w8_y_a", 16'(y8), 16'h005A);
    tick();
    check("w8_y_q_a", 16'(y_q8), 16'h005A);
    s8 = 1'b1;
    #1;
    check("w8_y_b", 16'(y8), 16'h00A5);
    check("w8_y_q_hold", 16'(y_q8), 16'h005A);
    tick();
    check("w8_y_q_b", 16'(y_q8), 16'h00A5);
    check("w8_cnt", sw_cnt8, 16'd1);

    // Narrow counter saturation.
    for (int i = 0; i < 6; i++) begin
      s2 = ~s2;
      tick();
      check($sformatf("sat_cnt_%0d", i), 16'(sw_cnt2), 16'(sat_exp[i]));
    end

    // Asynchronous reset between edges clears state at once.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cnt2", 16'(sw_cnt2), 16'h0);
    check("async_cnt1", sw_cnt1, 16'h0);
    check("async_y_q8", 16'(y_q8), 16'h0);
    check("async_y8", 16'(y8), 16'h00A5);
    #2;
    rst_n = 1'b1;
    s2 = 1'b0;
    tick();
    check("post_rst_cnt2", 16'(sw_cnt2), 16'h0);
    check("post_rst_y_q8", 16'(y_q8), 16'h00A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux21_a

// File: doc/mux21_a.md
MUX21_A -- requirements
Module: mux21_a

Interface
Parameters (one per line: name, default, meaning):
REQ-001 WIDTH, 1, bit width of data inputs a, b and outputs y, y_q; SHALL be legal for any value >= 1.
REQ-002 CNT_W, 16, bit width of the select-switch counter sw_cnt; SHALL be legal for any value >= 2.

Ports (one per line: name  direction  width  meaning):
REQ-003 clk  input  1  single system clock; all sequential logic SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 s  input  1  select; 0 selects a, 1 selects b.
REQ-006 a  input  WIDTH  data input routed when s=0.
REQ-007 b  input  WIDTH  data input routed when s=1.
REQ-008 y  output  WIDTH  combinational mux output.
REQ-009 y_q  output  WIDTH  registered copy of y.
REQ-010 sw_cnt  output  CNT_W  saturating count of select transitions.

Function
REQ-011 y SHALL equal a when s=0 and b when s=1, with zero clock latency and purely combinational logic.
REQ-012 y SHALL follow any change on a, b or s within the same delta/settling time, independent of clk and rst_n.
REQ-013 y SHALL remain functional and correct while rst_n is asserted.
REQ-014 y_q SHALL capture y on each rising clk edge, giving exactly one cycle of latency.
REQ-015 An internal register s_q SHALL capture s on each rising clk edge.
REQ-016 On a rising clk edge where s differs from s_q, sw_cnt SHALL increment by 1.
REQ-017 sw_cnt SHALL saturate at all-ones (2^CNT_W - 1) and hold that value; it SHALL never wrap to 0.
REQ-018 On a rising clk edge where s equals s_q, sw_cnt SHALL hold its value.
REQ-019 Changes on s between clock edges that return to the original value before the next edge SHALL NOT be counted.
REQ-020 Unused or unknown input values SHALL NOT create latches; all outputs SHALL be fully assigned on every path.

Reset
REQ-021 When rst_n=0, y_q, s_q and sw_cnt SHALL clear to 0 immediately, regardless of clk.
REQ-022 Reset SHALL have priority over any simultaneous clock edge.
REQ-023 On the first rising edge after rst_n deasserts, s=1 SHALL count as one transition, because s_q resets to 0.
REQ-024 Asserting reset mid-operation SHALL discard the count and the registered output; there SHALL be no partial state retention.

Structure
REQ-025 A shared package mux21_pkg SHALL hold the default constants MUX21_WIDTH_DEF=1 and MUX21_CNT_W_DEF=16.
REQ-026 The combinational select SHALL be a sub-module mux21_core (ports s, a, b, y; parameter WIDTH) instantiated once.
REQ-027 The top level SHALL contain only the mux21_core instance, the y_q register, s_q and the saturating counter.

Verification
REQ-028 WIDTH=1, sweep {a,b,s} through 000,010,100,110,001,011,101,111 at 10-time-unit steps -> y = 0,0,1,1,0,1,0,1 respectively, each checked without any clk edge.
REQ-029 WIDTH=8, a=0x5A, b=0xA5, s=0 then s=1 -> y=0x5A then 0xA5 immediately; y_q matches each value one rising edge later.
REQ-030 rst_n=0 with a=1, b=0, s=0 -> y=1 while y_q=0 and sw_cnt=0.
REQ-031 After reset, toggle s every cycle for 5 cycles starting from s=1 -> sw_cnt=5; then hold s for 3 cycles -> sw_cnt stays 5.
REQ-032 CNT_W=2, toggle s for 6 cycles -> sw_cnt reads 1,2,3,3,3,3 (saturates at 3); then assert rst_n=0 between edges -> sw_cnt=0 at once.
REQ-033 Glitch s 0->1->0 between two edges -> sw_cnt unchanged, while y shows b during the glitch.
